bitstream_word_packer: RTL
==========================

# bitstream_word_packer

Receive-side counterpart of the USB byte-stream source: consumes the 8-bit valid/ready stream arriving from the USB endpoint and packs it into 32-bit configuration words for the fabric configuration write port. It hunts for a sync word, then emits one `word_write_strobe_o` per four accepted bytes, first byte in the MSB, until a desync word ends the session. It sits between the USB CDC/bulk endpoint and the frame/config writer.

## Interface
- `SYNC_WORD`, 32'hFAB0_FAB1, pattern that opens a session; never emitted.
- `DESYNC_WORD`, 32'hFAB0_FAB0, word that closes a session; never emitted.
- `clk_i` input 1 single clock; all logic on rising edge.
- `reset_i` input 1 asynchronous, active-high reset.
- `out_data_i` input 8 stream byte from the USB endpoint.
- `out_valid_i` input 1 byte on `out_data_i` is valid.
- `out_ready_o` output 1 packer accepts a byte this cycle.
- `write_busy_i` input 1 downstream cannot take a word this cycle.
- `write_data_o` output 32 packed word; stable while a word is pending.
- `word_write_strobe_o` output 1 one-cycle pulse, `write_data_o` valid.
- `active_o` output 1 session open (state ACTIVE).
- `word_count_o` output 16 words strobed since last sync, saturating at 16'hFFFF.

## Operation
- Byte accepted ("beat") on a rising edge with `out_valid_i && out_ready_o`. No other edge changes shift or pack state.
- `out_ready_o = !pending` (pending = packed word not yet strobed).
- States:
  - HUNT: each beat shifts `hunt_sr <= {hunt_sr[23:0], out_data_i}`. If `{hunt_sr[23:0], out_data_i} == SYNC_WORD`, go to ACTIVE, clear byte index, `word_count_o <= 0`, clear `hunt_sr`.
  - ACTIVE: beats fill `pack[31:24]`, `[23:16]`, `[15:8]`, `[7:0]` in order (byte index 0..3, wraps 3->0). On the 4th beat:
    - If assembled word == `DESYNC_WORD`, go to HUNT, set no pending, emit no strobe. `word_count_o` holds.
    - Otherwise load `write_data_o` and set pending.
- Strobe: `word_write_strobe_o = pending && !write_busy_i` (combinational). Pending clears on the edge where the strobe is high, and `word_count_o` increments on that edge (saturating).
- While pending, `out_ready_o = 0`. Upstream must hold `out_data_i`/`out_valid_i`; the packer never drops or duplicates a byte.
- Sync matching in HUNT is byte-aligned at any offset; garbage/preamble bytes before sync are discarded.
- A second `SYNC_WORD` inside ACTIVE is treated as data and strobed.
- Reset, including mid-word or with pending set:
  - state HUNT, `hunt_sr`, `pack` and byte index 0, `write_data_o` 32'h0.
  - pending 0, so `out_ready_o` = 1 and `word_write_strobe_o` = 0.
  - `active_o` 0, `word_count_o` 0.
  - A partial word is discarded.

## Timing
- Latency: 4th byte beat at edge N. `write_data_o` valid and pending from after edge N. Strobe in cycle N+1 if `write_busy_i = 0`.
- Throughput: 4 bytes per 5 cycles minimum, since ready drops for at least one cycle per word.
- `write_busy_i` high delays the strobe indefinitely; `write_data_o` is held and ready stays low.
- `active_o` rises the cycle after the final sync byte beat. It falls the cycle after the final desync byte beat.
- `active_o` and `word_count_o` are registered outputs. Ready and strobe depend only on pending and `write_busy_i`; there is no combinational path from `out_valid_i`.

## Test plan
- Stream 16 bytes 8'h00, then FA B0 FA B1, then 12 34 56 78, back-to-back valid, busy=0 -> exactly one strobe with `write_data_o` = 32'h12345678; `word_count_o` = 1; `active_o` = 1.
- Sync at odd offset (bytes AA FA B0 FA B1 DE AD BE EF) -> one strobe, 32'hDEADBEEF; the AA byte is ignored.
- After sync, hold `write_busy_i` = 1 for 5 cycles once 32'h01020304 is packed -> ready low and data held throughout; a single strobe in the first cycle busy=0; the next byte is accepted the following edge.
- After sync, send 01 02 03 04, then FA B0 FA B0, then 05 06 07 08 -> one strobe (32'h01020304); `active_o` drops; 05..08 produce no strobe.
- Assert `reset_i` after 2 bytes of a word, then re-sync and send 11 22 33 44 -> all outputs at reset values during reset; next strobe is 32'h11223344 (no stale bytes).
- Random `out_valid_i` gaps with 64 data words after sync -> 64 strobes, matching big-endian golden words in order; `word_count_o` = 64.

Source files
------------

// File: rtl/bitstream_word_packer.sv
// Packs a byte stream into big-endian 32-bit configuration words.
// Words are framed by a sync word and a desync word, and neither of those is emitted.
module bitstream_word_packer #(
  parameter logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1,
  parameter logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [7:0]  out_data_i,
  input  logic        out_valid_i,
  output logic        out_ready_o,
  input  logic        write_busy_i,
  output logic [31:0] write_data_o,
  output logic        word_write_strobe_o,
  output logic        active_o,
  output logic [15:0] word_count_o
);

  typedef enum logic {HUNT, ACTIVE} state_t;

  state_t      state;
  logic [23:0] hunt_sr;
  logic [23:0] pack;
  logic [1:0]  byte_idx;
  logic        pending;
  logic        beat;
  logic [31:0] hunt_next;
  logic [31:0] word_next;

  // Ready and strobe depend only on pending and busy, never on out_valid_i.
  assign out_ready_o         = !pending;
  assign word_write_strobe_o = pending && !write_busy_i;
  assign beat                = out_valid_i && !pending;
  assign active_o            = (state == ACTIVE);

  assign hunt_next = {hunt_sr, out_data_i};
  assign word_next = {pack, out_data_i};

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state        <= HUNT;
      hunt_sr      <= '0;
      pack         <= '0;
      byte_idx     <= '0;
      pending      <= 1'b0;
      write_data_o <= '0;
      word_count_o <= '0;
    end else begin
      if (word_write_strobe_o) begin
        pending <= 1'b0;
        if (word_count_o != 16'hFFFF)
          word_count_o <= word_count_o + 16'd1;
      end
      if (beat) begin
        case (state)
          HUNT: begin
            if (hunt_next == SYNC_WORD) begin
              state        <= ACTIVE;
              byte_idx     <= '0;
              word_count_o <= '0;
              hunt_sr      <= '0;
            end else begin
              hunt_sr <= hunt_next[23:0];
            end
          end
          ACTIVE: begin
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: pack[23:16] <= out_data_i;
              2'd1: pack[15:8]  <= out_data_i;
              2'd2: pack[7:0]   <= out_data_i;
              default: begin
                // The closing word only ends the session and never reaches the writer.
                if (word_next == DESYNC_WORD) begin
                  state <= HUNT;
                end else begin
                  write_data_o <= word_next;
                  pending      <= 1'b1;
                end
              end
            endcase
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
